// File: rtl/axi_wr_burst_arb_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst arbiter and the
// downstream DDR interconnect.
//   master : arbiter side, drives AW/W payloads and bready
//   slave  : interconnect side, drives awready/wready and the B channel
interface axi_wr_burst_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [3:0]              awcache;
    logic                    awid;
    logic                    awlock;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic                    bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awcache, awid, awlock, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awcache, awid, awlock, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_wr_burst_arb.sv
// Burst-granular round-robin arbiter sharing one AXI4 write port between
// NUM_REQ stream writers. Each writer owns a ring region starting at
// BASE_ADDR + k*REGION_SIZE; one burst is outstanding at a time and the
// grant is held from AW issue until the B response is accepted.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : per-writer "full burst available" request
//   o_grant        : one-hot grant
//   s_tdata/s_tvalid/s_tready : flattened writer streams
//   m_axi          : AXI4 AW/W/B master port
//   o_bresp_err    : sticky per-writer non-OKAY response flag
//
// state | meaning
// IDLE  | no burst in flight, pick next winner
// ADDR  | AW beat presented, waiting for awready
// DATA  | granted stream steered onto W
// RESP  | waiting for B response
module axi_wr_burst_arb #(
    parameter int                    NUM_REQ     = 4,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    BURST_LEN   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_WIDTH-1:0] REGION_SIZE = ADDR_WIDTH'(32'h0100_0000)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    output logic [NUM_REQ-1:0]            o_grant,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]            s_tvalid,
    output logic [NUM_REQ-1:0]            s_tready,
    axi_wr_burst_arb_if.master            m_axi,
    output logic [NUM_REQ-1:0]            o_bresp_err
);

    localparam int                  IDX_W       = $clog2(NUM_REQ);
    localparam int                  BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam logic [7:0]          AWLEN       = 8'(BURST_LEN - 1);
    localparam logic [2:0]          AWSIZE      = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [ADDR_WIDTH:0] BURST_STEP  = (ADDR_WIDTH + 1)'(BURST_BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                state;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      last_winner;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_found;
    int                    cand;
    logic [7:0]            beat_cnt;
    logic [ADDR_WIDTH-1:0] offset [NUM_REQ];
    logic [ADDR_WIDTH-1:0] aw_addr_next;
    logic [ADDR_WIDTH:0]   off_sum;
    logic [ADDR_WIDTH-1:0] off_next;
    logic [DATA_WIDTH-1:0] tdata_arr [NUM_REQ];
    logic                  w_hs;
    logic                  unused_bid;

    assign unused_bid = m_axi.bid;

    // Round-robin search starting one past the previous winner, with wrap.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_winner) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && i_req[IDX_W'(cand)]) begin
                win_idx   = IDX_W'(cand);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            tdata_arr[k] = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign aw_addr_next = BASE_ADDR + ADDR_WIDTH'(win_idx) * REGION_SIZE + offset[win_idx];

    // One extra bit so an offset step landing past the top of the address
    // space still compares correctly against REGION_SIZE.
    assign off_sum  = {1'b0, offset[grant_idx]} + BURST_STEP;
    assign off_next = (off_sum >= {1'b0, REGION_SIZE}) ? '0 : off_sum[ADDR_WIDTH-1:0];

    assign m_axi.wvalid  = (state == DATA) && s_tvalid[grant_idx];
    assign m_axi.wdata   = tdata_arr[grant_idx];
    assign m_axi.wlast   = (state == DATA) && (beat_cnt == AWLEN);
    assign m_axi.wstrb   = '1;
    assign s_tready      = ((state == DATA) && m_axi.wready) ? o_grant : '0;
    assign w_hs          = m_axi.wvalid && m_axi.wready;

    assign m_axi.awcache = 4'b0011;
    assign m_axi.awid    = 1'b0;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awqos   = 4'b0000;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            grant_idx      <= '0;
            last_winner    <= IDX_W'(NUM_REQ - 1);
            o_grant        <= '0;
            beat_cnt       <= '0;
            o_bresp_err    <= '0;
            m_axi.awaddr   <= '0;
            m_axi.awlen    <= '0;
            m_axi.awsize   <= '0;
            m_axi.awburst  <= '0;
            m_axi.awvalid  <= 1'b0;
            m_axi.bready   <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                offset[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state         <= ADDR;
                        grant_idx     <= win_idx;
                        o_grant       <= NUM_REQ'(1) << win_idx;
                        m_axi.awaddr  <= aw_addr_next;
                        m_axi.awlen   <= AWLEN;
                        m_axi.awsize  <= AWSIZE;
                        m_axi.awburst <= 2'b01;
                        m_axi.awvalid <= 1'b1;
                    end
                end
                ADDR: begin
                    if (m_axi.awready) begin
                        m_axi.awvalid <= 1'b0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        if (m_axi.wlast) begin
                            beat_cnt     <= '0;
                            m_axi.bready <= 1'b1;
                            state        <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (m_axi.bvalid) begin
                        m_axi.bready      <= 1'b0;
                        offset[grant_idx] <= off_next;
                        if (m_axi.bresp != 2'b00) begin
                            o_bresp_err[grant_idx] <= 1'b1;
                        end
                        last_winner <= grant_idx;
                        o_grant     <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_arb.sv
// Self-checking bench for axi_wr_burst_arb: directed request patterns with
// hand-computed AW addresses/grants queued as expectations, a responder
// process acting as writer sources and AXI slave, and a monitor that pops
// and compares on every AW/W/B handshake.
module tb_axi_wr_burst_arb;

    localparam int          NREQ   = 4;
    localparam int          AW     = 32;
    localparam int          DW     = 64;
    localparam int          BLEN   = 16;
    localparam logic [31:0] BASE   = 32'h0;
    localparam logic [31:0] REGION = 32'h100;

    logic               i_clk;
    logic               i_rst_n;
    logic [NREQ-1:0]    i_req;
    logic [NREQ-1:0]    o_grant;
    logic [NREQ*DW-1:0] s_tdata;
    logic [NREQ-1:0]    s_tvalid;
    logic [NREQ-1:0]    s_tready;
    logic [NREQ-1:0]    o_bresp_err;

    axi_wr_burst_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

    axi_wr_burst_arb #(
        .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BLEN),
        .BASE_ADDR(BASE), .REGION_SIZE(REGION)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_grant(o_grant),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_axi(m_axi.master), .o_bresp_err(o_bresp_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct { logic [3:0] g; logic [31:0] a; } aw_t;
    typedef struct { logic [63:0] d; logic l; } w_t;

    aw_t aw_q[$];
    w_t  w_q[$];

    int checks = 0;
    int errors = 0;
    int aw_cnt = 0;
    int b_cnt  = 0;
    int beats  = 0;
    int seq   [NREQ];
    int m_seq [NREQ];
    bit stall = 1'b0;
    logic [3:0] bad_mask = 4'b0000;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int k, input int s);
        return {8'(k), 24'h5A5A5A, 32'(s)};
    endfunction

    task automatic push_exp(input logic [3:0] g, input logic [31:0] a);
        aw_t e;
        w_t  w;
        int  k;
        k = 0;
        for (int i = 0; i < NREQ; i++) if (g[i]) k = i;
        e.g = g;
        e.a = a;
        aw_q.push_back(e);
        for (int i = 0; i < BLEN; i++) begin
            w.d = pat(k, m_seq[k] + i);
            w.l = (i == BLEN - 1);
            w_q.push_back(w);
        end
        m_seq[k] += BLEN;
    endtask

    // Writer sources and AXI slave. Inputs change on the falling edge;
    // handshakes that the next rising edge will take are noted 2ns later.
    initial begin : env
        bit hs_t [NREQ];
        bit hs_b, hs_wl, b_pend;
        hs_b = 0; hs_wl = 0; b_pend = 0;
        for (int k = 0; k < NREQ; k++) begin seq[k] = 0; hs_t[k] = 0; end
        s_tvalid = '0; s_tdata = '0;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0;
        m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00; m_axi.bid = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                m_axi.bvalid = 1'b0;
                b_pend = 0;
            end else begin
                for (int k = 0; k < NREQ; k++) if (hs_t[k]) seq[k]++;
                if (hs_b) m_axi.bvalid = 1'b0;
                if (hs_wl) b_pend = 1;
                if (b_pend && !m_axi.bvalid) begin
                    m_axi.bvalid = 1'b1;
                    m_axi.bresp  = ((o_grant & bad_mask) != 0) ? 2'b10 : 2'b00;
                    b_pend = 0;
                end
            end
            m_axi.awready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_axi.wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            for (int k = 0; k < NREQ; k++) begin
                s_tvalid[k] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_tdata[k*DW +: DW] = pat(k, seq[k]);
            end
            #2;
            for (int k = 0; k < NREQ; k++) hs_t[k] = s_tvalid[k] && s_tready[k];
            hs_b  = m_axi.bvalid && m_axi.bready;
            hs_wl = m_axi.wvalid && m_axi.wready && m_axi.wlast;
        end
    end

    initial begin : monitor
        aw_t e;
        w_t  w;
        bit  b_prev, exp_aw;
        b_prev = 0; exp_aw = 0;
        forever begin
            @(negedge i_clk);
            #2;
            if (!i_rst_n) begin
                b_prev = 0;
                exp_aw = 0;
            end else begin
                check("tready_nongranted", 64'(s_tready & ~o_grant), 64'd0);
                check("grant_onehot", 64'($onehot0(o_grant)), 64'd1);
                if (m_axi.awvalid) check("no_w_before_aw", 64'({m_axi.wvalid, s_tready}), 64'd0);
                if (m_axi.bready) check("no_w_in_resp", 64'({m_axi.wvalid, s_tready}), 64'd0);
                if (exp_aw) begin
                    check("b2b_awvalid", 64'(m_axi.awvalid), 64'd1);
                    exp_aw = 0;
                end
                if (b_prev) begin
                    check("idle_gap_awvalid", 64'(m_axi.awvalid), 64'd0);
                    exp_aw = (i_req != 0);
                    b_prev = 0;
                end
                if (m_axi.awvalid && m_axi.awready) begin
                    aw_cnt++;
                    beats = 0;
                    if (aw_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aw_unexpected actual=%h required=none", m_axi.awaddr);
                    end else begin
                        e = aw_q.pop_front();
                        check("awaddr", 64'(m_axi.awaddr), 64'(e.a));
                        check("grant", 64'(o_grant), 64'(e.g));
                        check("awlen", 64'(m_axi.awlen), 64'd15);
                        check("awsize", 64'(m_axi.awsize), 64'd3);
                        check("awburst", 64'(m_axi.awburst), 64'd1);
                        check("awcache", 64'(m_axi.awcache), 64'd3);
                        check("wstrb", 64'(m_axi.wstrb), 64'hFF);
                    end
                end
                if (m_axi.wvalid && m_axi.wready) begin
                    beats++;
                    if (w_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w_unexpected actual=%h required=none", m_axi.wdata);
                    end else begin
                        w = w_q.pop_front();
                        check("wdata", m_axi.wdata, w.d);
                        check("wlast", 64'(m_axi.wlast), 64'(w.l));
                    end
                end
                if (m_axi.bvalid && m_axi.bready) begin
                    b_cnt++;
                    check("burst_beats", 64'(beats), 64'(BLEN));
                    b_prev = 1;
                end
            end
        end
    end

    task automatic run(input logic [3:0] mask, input int n, input bit lat, input logic [3:0] lat_g);
        int aw_t, b_t, cyc;
        aw_t = aw_cnt + n;
        b_t  = b_cnt + n;
        @(negedge i_clk);
        i_req = mask;
        if (lat) begin
            @(negedge i_clk);
            #1;
            check("latency_awvalid", 64'(m_axi.awvalid), 64'd1);
            check("latency_grant", 64'(o_grant), 64'(lat_g));
        end
        cyc = 0;
        while (aw_cnt < aw_t && cyc < 500 * n) begin @(negedge i_clk); cyc++; end
        i_req = '0;
        if (aw_cnt < aw_t) begin
            checks++; errors++;
            $display("FAIL aw_timeout actual=%0d required=%0d", aw_cnt, aw_t);
        end
        cyc = 0;
        while (b_cnt < b_t && cyc < 500 * n) begin @(negedge i_clk); cyc++; end
        if (b_cnt < b_t) begin
            checks++; errors++;
            $display("FAIL b_timeout actual=%0d required=%0d", b_cnt, b_t);
        end
        repeat (3) @(negedge i_clk);
        check("aw_q_drained", 64'(aw_q.size()), 64'd0);
        check("w_q_drained", 64'(w_q.size()), 64'd0);
    endtask

    initial begin : main
        int cyc;
        for (int k = 0; k < NREQ; k++) m_seq[k] = 0;
        i_rst_n = 1'b0;
        i_req   = '0;
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_grant", 64'(o_grant), 64'd0);
        check("rst_awvalid", 64'(m_axi.awvalid), 64'd0);
        check("rst_awaddr", 64'(m_axi.awaddr), 64'd0);
        check("rst_awlen_size_burst", 64'({m_axi.awlen, m_axi.awsize, m_axi.awburst}), 64'd0);
        check("rst_w", 64'({m_axi.wvalid, m_axi.wlast, s_tready}), 64'd0);
        check("rst_bready", 64'(m_axi.bready), 64'd0);
        check("rst_bresp_err", 64'(o_bresp_err), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // All four requesting: order 0,1,2,3,0; region 0 second burst at +0x80.
        push_exp(4'b0001, 32'h000);
        push_exp(4'b0010, 32'h100);
        push_exp(4'b0100, 32'h200);
        push_exp(4'b1000, 32'h300);
        push_exp(4'b0001, 32'h080);
        run(4'b1111, 5, 1'b1, 4'b0001);

        // Requester 0 alone: offset 0x100 wrapped to 0, then 0x80.
        push_exp(4'b0001, 32'h000);
        push_exp(4'b0001, 32'h080);
        run(4'b0001, 2, 1'b1, 4'b0001);

        // Requester 1 alone: 0x180, wrap to 0x100, then 0x180.
        push_exp(4'b0010, 32'h180);
        push_exp(4'b0010, 32'h100);
        push_exp(4'b0010, 32'h180);
        run(4'b0010, 3, 1'b0, 4'b0000);

        // Stalls on every channel, SLVERR on requester 2's burst.
        stall    = 1'b1;
        bad_mask = 4'b0100;
        push_exp(4'b0100, 32'h280);
        push_exp(4'b1000, 32'h380);
        run(4'b1100, 2, 1'b0, 4'b0000);
        check("bresp_err_set", 64'(o_bresp_err), 64'h4);
        bad_mask = 4'b0000;
        push_exp(4'b0100, 32'h200);
        run(4'b0100, 1, 1'b0, 4'b0000);
        check("bresp_err_sticky", 64'(o_bresp_err), 64'h4);
        stall = 1'b0;

        // Reset while beat 5 of requester 1's burst is on the bus.
        push_exp(4'b0010, 32'h100);
        @(negedge i_clk);
        i_req = 4'b0010;
        cyc = 0;
        while (beats != 5 && cyc < 200) begin @(negedge i_clk); #3; cyc++; end
        if (beats != 5) begin
            checks++; errors++;
            $display("FAIL beat5_timeout actual=%0d required=5", beats);
        end
        i_rst_n = 1'b0;
        #1;
        check("arst_awvalid", 64'(m_axi.awvalid), 64'd0);
        check("arst_wvalid", 64'(m_axi.wvalid), 64'd0);
        check("arst_grant", 64'(o_grant), 64'd0);
        check("arst_tready_bready", 64'({s_tready, m_axi.bready}), 64'd0);
        check("arst_bresp_err", 64'(o_bresp_err), 64'd0);
        i_req = '0;
        aw_q.delete();
        w_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < NREQ; k++) m_seq[k] = seq[k];
        push_exp(4'b0001, 32'h000);
        push_exp(4'b0010, 32'h100);
        run(4'b0011, 2, 1'b1, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_wr_burst_arb.md
# axi_wr_burst_arb

Burst-granular round-robin arbiter that shares one AXI4 write master port between NUM_REQ stream writers. Each writer raises a request once it holds a full burst. The arbiter grants one writer at a time, issues the AW beat with an address taken from that writer's private ring region, and steers the writer's stream onto W. It releases the grant only after the B response, and sits between the per-channel capture FIFOs and the DDR interconnect.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2–8).
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 64: AXI data width (32/64/128).
- BURST_LEN, 16: beats per burst (1–256); awlen = BURST_LEN-1.
- BASE_ADDR, 32'h0000_0000: start of region 0.
- REGION_SIZE, 32'h0100_0000: bytes per requester region; must be a multiple of BURST_LEN*DATA_WIDTH/8.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  NUM_REQ  per-requester burst-ready request.
- o_grant  out  NUM_REQ  one-hot grant, held from AW issue until B accepted.
- s_tdata  in  NUM_REQ*DATA_WIDTH  flattened requester data; slice k = [k*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  in  NUM_REQ  requester data valid.
- s_tready  out  NUM_REQ  requester data ready.
- m_axi_aw*  out  awaddr ADDR_WIDTH, awlen 8, awsize 3, awburst 2, awcache 4, awid/awlock 1, awprot 3, awqos 4, awvalid 1; plus m_axi_awready in 1.
- m_axi_w*  out  wdata DATA_WIDTH, wstrb DATA_WIDTH/8, wlast 1, wvalid 1; plus m_axi_wready in 1.
- m_axi_b*  in  bid 1, bresp 2, bvalid 1; plus m_axi_bready out 1.
- o_bresp_err  out  NUM_REQ  sticky per-requester flag: a non-OKAY response was received.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE → ADDR when |i_req.
  - Winner is the first set bit searching from (last_winner+1) mod NUM_REQ upward with wrap.
  - last_winner resets to NUM_REQ-1, so requester 0 has first priority.
  - On this transition the arbiter registers o_grant, awaddr and awvalid=1.
- ADDR → DATA on awvalid && awready; awvalid drops the same edge.
- DATA:
  - m_axi_wvalid = s_tvalid[g], m_axi_wdata = s_tdata slice g, s_tready[g] = m_axi_wready.
  - All other s_tready bits are 0.
  - The beat counter increments on each wvalid && wready.
  - wlast = (beat_cnt == BURST_LEN-1), combinational from the registered counter.
  - DATA → RESP on the handshake with wlast=1; the counter clears.
- RESP: bready=1. On bvalid → IDLE.
  - The granted requester's offset advances by BURST_LEN*DATA_WIDTH/8.
  - The offset wraps to 0 when the new offset would be ≥ REGION_SIZE.
  - If bresp≠2'b00, set o_bresp_err[g].
  - last_winner ← g and o_grant ← 0.
- awaddr = BASE_ADDR + g*REGION_SIZE + offset[g]. Arithmetic is ADDR_WIDTH-wide and truncated modulo 2^ADDR_WIDTH.
- Constant AXI fields:
  - awsize = log2(DATA_WIDTH/8), awburst = 2'b01, awcache = 4'b0011.
  - awid/awlock/awprot/awqos = 0.
  - wstrb = all ones.
- i_req deassertion after grant is ignored; the burst completes. Requests arriving mid-burst wait for IDLE.
- o_bresp_err clears only on reset.

## Timing
- Reset values:
  - o_grant=0, awvalid=0, awaddr=0, awlen/awsize/awburst=0.
  - wvalid=0, wlast=0, s_tready=0, bready=0, o_bresp_err=0.
  - All offsets=0, beat_cnt=0, state=IDLE.
- Latency: request sampled high at edge n gives awvalid=1 and o_grant valid after edge n (cycle n+1).
- Back-to-back: bvalid accepted at edge m; a pending request gives awvalid again after edge m+1, so there is one IDLE cycle.
- Only one outstanding burst; AW always precedes W, with no W beats before AW acceptance.
- wvalid/s_tready are 0 in IDLE, ADDR and RESP.
- Reset mid-burst: all outputs return to reset values immediately and asynchronously. Partial bursts are abandoned; the downstream slave is reset alongside.

## Test plan
- Single requester 0, awready/wready=1, 16 beats → awaddr=0x0, awlen=15, awsize=3, wlast on beat 16; second burst awaddr=0x80.
- All four i_req high continuously → grant order 0,1,2,3,0; awaddr 0x0, 0x0100_0000, 0x0200_0000, 0x0300_0000, then 0x80.
- REGION_SIZE=0x100, BURST_LEN=16, DATA_WIDTH=64 → requester 1 addresses 0x100, 0x180, 0x100 (wrap).
- Random wready/s_tvalid stalls → exactly 16 beats, wlast only on beat 16, s_tready of non-granted requesters stays 0.
- bresp=2'b10 on requester 2's burst → o_bresp_err=4'b0100 sticky; offset still advances.
- Assert i_rst_n low during DATA beat 5 → awvalid/wvalid/o_grant=0 at once; after release, first burst restarts at awaddr=BASE.
